// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared pooling constants and sequencer state encoding
package lenet_pkg;

  localparam int POOL_WD    = 8;
  localparam int POOL_LANES = 8;
  localparam logic [POOL_WD-1:0] POOL_NEG_MIN = {1'b1, {(POOL_WD-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_e;

endpackage

// File: rtl/pool_out_reg.sv
// rtl/pool_out_reg.sv - pooled-word capture/hold register with valid/ready handshake
// Build option: RELU_EN clamps negative 2*WD lanes to zero at capture.
module pool_out_reg #(
  parameter int WD    = 8,
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [2*LANES*WD-1:0] cap_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [2*LANES*WD-1:0] out_data
);

  localparam int LW = 2 * WD;

  logic                  valid_q, valid_d;
  logic [2*LANES*WD-1:0] data_q, data_d;
  logic [2*LANES*WD-1:0] cap_word;

  always_comb begin
    cap_word = cap_data;
`ifdef RELU_EN
    for (int i = 0; i < LANES; i++) begin
      if (cap_data[i*LW + LW-1]) cap_word[i*LW +: LW] = '0;
    end
`endif
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    // A capture in the same cycle as an acceptance keeps the register full.
    if (capture) begin
      valid_d = 1'b1;
      data_d  = cap_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pool_window_ctrl.sv
// rtl/pool_window_ctrl.sv - max-pool window sequencer and ofmap write-back stage
// Build option: RELU_EN fuses ReLU into the captured pooled word.
module pool_window_ctrl
  import lenet_pkg::*;
#(
  parameter int WD    = POOL_WD,
  parameter int LANES = POOL_LANES,
  parameter int WIN   = 4,
  parameter int N_OUT = 196,
  parameter int AW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*WD-1:0]   in_data,
  output logic [LANES*WD-1:0]   cmp_data,
  output logic                  poolwrite,
  input  logic [2*LANES*WD-1:0] cmp_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*LANES*WD-1:0] out_data,
  output logic [AW-1:0]         out_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int OCW = $clog2(N_OUT + 1);
  localparam logic [WD-1:0] NEG_MIN = {1'b1, {(WD-1){1'b0}}};

  pool_state_e    state_q, state_d;
  logic [WCW-1:0] win_cnt_q, win_cnt_d;
  logic [OCW-1:0] cap_cnt_q, cap_cnt_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           fire, win_last, capture, accept;

  assign in_ready = (state_q == ST_RUN) && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;
  assign win_last = (win_cnt_q == WCW'(WIN - 1));
  assign capture  = fire && win_last;
  assign accept   = out_valid && out_ready;

  // Non-firing cycles feed the most negative value so they never win the max.
  assign cmp_data  = fire ? in_data : {LANES{NEG_MIN}};
  assign poolwrite = !rst || (state_q != ST_RUN) || capture;

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign out_addr = addr_q;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    cap_cnt_d = cap_cnt_q;
    out_cnt_d = out_cnt_q;
    addr_d    = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          addr_d    = base_addr;
          win_cnt_d = '0;
          cap_cnt_d = '0;
          out_cnt_d = '0;
        end
      end
      ST_RUN:   if (capture && (cap_cnt_q == OCW'(N_OUT - 1))) state_d = ST_DRAIN;
      ST_DRAIN: if (accept && (out_cnt_q == OCW'(N_OUT - 1))) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (fire)    win_cnt_d = win_last ? '0 : win_cnt_q + 1'b1;
    if (capture) cap_cnt_d = cap_cnt_q + 1'b1;
    if (accept) begin
      out_cnt_d = out_cnt_q + 1'b1;
      addr_d    = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      cap_cnt_q <= '0;
      out_cnt_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      out_cnt_q <= out_cnt_d;
      addr_q    <= addr_d;
    end
  end

  pool_out_reg #(
    .WD    (WD),
    .LANES (LANES)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .cap_data  (cmp_result),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_pool_window_ctrl.sv
// tb/tb_pool_window_ctrl.sv - scoreboard bench for pool_window_ctrl with a comparator model
// Build option: RELU_EN changes the expected pooled words.
module tb_pool_window_ctrl;
  import lenet_pkg::*;

  localparam int WD = 8, LANES = 8, WIN = 4, AW = 10, NA = 2, NB = 196;
  localparam int IW = LANES * WD, OW = 2 * LANES * WD;
  localparam logic [WD-1:0] NEG = POOL_NEG_MIN;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [OW-1:0] data;
  } word_t;

  word_t exp_q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start_a, start_b, in_valid, out_ready, sel;
  logic [AW-1:0] base_addr;
  logic [IW-1:0] in_data;

  logic          a_in_ready, a_poolwrite, a_out_valid, a_busy, a_done;
  logic [IW-1:0] a_cmp_data;
  logic [OW-1:0] a_cmp_result, a_out_data;
  logic [AW-1:0] a_out_addr;
  logic          b_in_ready, b_poolwrite, b_out_valid, b_busy, b_done;
  logic [IW-1:0] b_cmp_data;
  logic [OW-1:0] b_cmp_result, b_out_data;
  logic [AW-1:0] b_out_addr;

  int checks = 0, errors = 0;
  int cyc_n = 0, done_a_n = 0, done_b_n = 0, acc_n = 0, last_acc = -1;
  bit rate_chk = 1'b0;
  logic [IW-1:0] acc;

  pool_window_ctrl #(.WD(WD), .LANES(LANES), .WIN(WIN), .N_OUT(NA), .AW(AW)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .cmp_data(a_cmp_data), .poolwrite(a_poolwrite), .cmp_result(a_cmp_result),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_addr(a_out_addr), .busy(a_busy), .done(a_done)
  );

  pool_window_ctrl #(.WD(WD), .LANES(LANES), .WIN(WIN), .N_OUT(NB), .AW(AW)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .cmp_data(b_cmp_data), .poolwrite(b_poolwrite), .cmp_result(b_cmp_result),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_addr(b_out_addr), .busy(b_busy), .done(b_done)
  );

  function automatic logic [IW-1:0] lane_max(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*WD +: WD] = ($signed(b[i*WD +: WD]) > $signed(a[i*WD +: WD])) ? b[i*WD +: WD] : a[i*WD +: WD];
    return r;
  endfunction

  // Comparator output format: each lane max sign-extended to 2*WD and scaled by 8.
  function automatic logic [OW-1:0] widen(input logic [IW-1:0] m);
    logic [OW-1:0]   r;
    logic [2*WD-1:0] w;
    for (int i = 0; i < LANES; i++) begin
      w = {{WD{m[i*WD + WD-1]}}, m[i*WD +: WD]};
      r[i*2*WD +: 2*WD] = w << 3;
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] expect_word(input logic [IW-1:0] m);
    logic [OW-1:0] r;
    r = widen(m);
`ifdef RELU_EN
    for (int i = 0; i < LANES; i++)
      if (r[i*2*WD + 2*WD-1]) r[i*2*WD +: 2*WD] = '0;
`endif
    return r;
  endfunction

  function automatic logic [IW-1:0] l0(input int v);
    logic [IW-1:0] r;
    r = '0;
    r[WD-1:0] = v[WD-1:0];
    return r;
  endfunction

  logic [IW-1:0] run_a, run_b;
  always_ff @(posedge clk) begin
    run_a <= a_poolwrite ? {LANES{NEG}} : lane_max(run_a, a_cmp_data);
    run_b <= b_poolwrite ? {LANES{NEG}} : lane_max(run_b, b_cmp_data);
  end
  assign a_cmp_result = widen(lane_max(run_a, a_cmp_data));
  assign b_cmp_result = widen(lane_max(run_b, b_cmp_data));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take(input logic [OW-1:0] d, input logic [AW-1:0] a);
    word_t e;
    chk("word_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_data", d, e.data);
      chk("out_addr", a, e.addr);
    end
    if (rate_chk && last_acc >= 0) chk("word_interval", cyc_n - last_acc, WIN);
    last_acc = cyc_n;
    acc_n++;
  endtask

  task automatic cyc(output bit fired);
    logic [IW-1:0] cmp_obs;
    #1;
    fired   = in_valid && (sel ? b_in_ready : a_in_ready);
    cmp_obs = sel ? b_cmp_data : a_cmp_data;
    chk("cmp_data", cmp_obs, fired ? in_data : {LANES{NEG}});
    if (a_out_valid && out_ready) take(a_out_data, a_out_addr);
    if (b_out_valid && out_ready) take(b_out_data, b_out_addr);
    if (a_done) begin done_a_n++; chk("busy_at_done_a", a_busy, 1); end
    if (b_done) begin done_b_n++; chk("busy_at_done_b", b_busy, 1); end
    cyc_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_window(input logic [IW-1:0] b0, input logic [IW-1:0] b1,
                             input logic [IW-1:0] b2, input logic [IW-1:0] b3,
                             input bit gaps, input logic [AW-1:0] addr);
    logic [IW-1:0] bv [4];
    bit            f;
    word_t         w;
    bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
    acc = {LANES{NEG}};
    for (int k = 0; k < WIN; k++) begin
      if (gaps && k > 0) begin
        in_valid = 1'b0;
        in_data  = {LANES{8'h7f}};
        cyc(f);
      end
      in_valid = 1'b1;
      in_data  = bv[k];
      f = 1'b0;
      for (int t = 0; t < 40 && !f; t++) cyc(f);
      chk("beat_accepted", f, 1);
      acc = lane_max(acc, bv[k]);
      if (k == WIN - 1) begin
        w.addr = addr;
        w.data = expect_word(acc);
        exp_q.push_back(w);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start(input bit which, input logic [AW-1:0] base);
    bit f;
    sel = which;
    base_addr = base;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    cyc(f);
    start_a = 1'b0;
    start_b = 1'b0;
    base_addr = '1;
    chk("busy_after_start", which ? b_busy : a_busy, 1);
  endtask

  task automatic wait_idle(input bit which);
    bit f;
    int t;
    t = 0;
    in_valid = 1'b0;
    while ((which ? b_busy : a_busy) && t < 60) begin
      cyc(f);
      t++;
    end
    chk("idle_reached", which ? b_busy : a_busy, 0);
  endtask

  initial begin
    bit f;
    logic [AW-1:0] wa;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    base_addr = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    cyc(f);
    cyc(f);
    rst = 1'b1;

    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_addr", a_out_addr, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_poolwrite", a_poolwrite, 1);
    chk("rst_b_busy", b_busy, 0);

    in_valid = 1'b1;
    in_data  = l0(100);
    for (int k = 0; k < 3; k++) begin
      cyc(f);
      chk("idle_no_fire", f, 0);
    end
    in_valid = 1'b0;
    chk("idle_no_word", a_out_valid, 0);

    // basic 2x2 window, then the idle-gap window completes the two-word pass
    done_a_n = 0;
    do_start(0, 10'h010);
    send_window(l0(3), l0(-5), l0(7), l0(1), 1'b0, 10'h010);
    chk("basic_valid", a_out_valid, 1);
    chk("basic_addr", a_out_addr, 10'h010);
    chk("basic_word", a_out_data, 128'h0038);
    send_window(l0(-1), l0(-2), l0(-3), l0(-4), 1'b1, 10'h011);
`ifdef RELU_EN
    chk("gaps_word", a_out_data, 128'h0);
`else
    chk("gaps_word", a_out_data, 128'hfff8);
`endif
    chk("gaps_addr", a_out_addr, 10'h011);
    wait_idle(0);
    chk("basic_done_once", done_a_n, 1);
    chk("basic_queue_empty", exp_q.size(), 0);

    // back-pressure with a start pulse during RUN that must be ignored
    done_a_n = 0;
    do_start(0, 10'd5);
    out_ready = 1'b0;
    send_window(l0(10), l0(20), l0(-30), l0(5), 1'b0, 10'd5);
    in_valid = 1'b1;
    in_data  = l0(9);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin start_a = 1'b1; base_addr = 10'h2aa; end
      cyc(f);
      start_a = 1'b0;
      chk("bp_no_fire", f, 0);
      chk("bp_hold_valid", a_out_valid, 1);
      chk("bp_hold_addr", a_out_addr, 10'd5);
      chk("bp_hold_data", a_out_data, 128'h00a0);
    end
    out_ready = 1'b1;
    send_window(l0(9), l0(-9), l0(2), l0(0), 1'b0, 10'd6);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(f);
      chk("drain_hold_valid", a_out_valid, 1);
      chk("drain_no_done", a_done, 0);
      chk("drain_in_ready", a_in_ready, 0);
    end
    out_ready = 1'b1;
    wait_idle(0);
    chk("bp_done_once", done_a_n, 1);
    chk("bp_queue_empty", exp_q.size(), 0);

    // reset after two beats of a window
    do_start(0, 10'h020);
    in_valid = 1'b1;
    in_data  = l0(100);
    cyc(f);
    chk("rst_beat1", f, 1);
    in_data = l0(120);
    cyc(f);
    chk("rst_beat2", f, 1);
    in_valid = 1'b0;
    rst = 1'b0;
    cyc(f);
    rst = 1'b1;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_valid", a_out_valid, 0);
    chk("midrst_poolwrite", a_poolwrite, 1);

    // reset while a word is pending drops it
    do_start(0, 10'h030);
    out_ready = 1'b0;
    send_window(l0(50), l0(60), l0(70), l0(80), 1'b0, 10'h030);
    cyc(f);
    rst = 1'b0;
    cyc(f);
    rst = 1'b1;
    void'(exp_q.pop_back());
    chk("pend_rst_valid", a_out_valid, 0);
    chk("pend_rst_data", a_out_data, 0);
    out_ready = 1'b1;
    cyc(f);
    chk("pend_rst_no_word", acc_n, 4);

    done_a_n = 0;
    do_start(0, 10'h040);
    send_window(l0(1), l0(2), l0(4), l0(3), 1'b0, 10'h040);
    chk("restart_word", a_out_data, 128'h0020);
    send_window(l0(-7), l0(6), l0(-8), l0(0), 1'b0, 10'h041);
    wait_idle(0);
    chk("restart_done_once", done_a_n, 1);
    chk("restart_queue_empty", exp_q.size(), 0);

    // full-rate pass, addresses wrap at 2**AW
    done_b_n = 0;
    acc_n = 0;
    do_start(1, 10'h3a0);
    rate_chk = 1'b1;
    last_acc = -1;
    for (int w = 0; w < NB; w++) begin
      wa = 10'h3a0 + AW'(w);
      send_window({$urandom(), $urandom()}, {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, wa);
    end
    wait_idle(1);
    rate_chk = 1'b0;
    chk("full_words", acc_n, NB);
    chk("full_done_once", done_b_n, 1);
    chk("full_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
